// File: rtl/axil_master_sequencer.sv
// axil_master_sequencer: round-robin arbiter that shares one AXI4-Lite master
// port among num_req_p valid/ready requesters, one transaction at a time.
// Optional response watchdog: define AXIL_SEQ_TIMEOUT_EN.
module axil_master_sequencer #(
  parameter int num_req_p        = 2,
  parameter int addr_width_p     = 32,
  parameter int data_width_p     = 32,
  parameter int timeout_cycles_p = 4096
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [num_req_p-1:0]                req_v_i,
  output logic [num_req_p-1:0]                req_ready_o,
  input  logic [num_req_p-1:0]                req_we_i,
  input  logic [num_req_p*addr_width_p-1:0]   req_addr_i,
  input  logic [num_req_p*data_width_p-1:0]   req_data_i,
  input  logic [num_req_p*data_width_p/8-1:0] req_strb_i,
  output logic [num_req_p-1:0]                resp_v_o,
  input  logic [num_req_p-1:0]                resp_yumi_i,
  output logic [data_width_p-1:0]             resp_data_o,
  output logic                                resp_err_o,
  output logic                                timeout_o,
  output logic [addr_width_p-1:0]             m01_axi_awaddr,
  output logic [2:0]                          m01_axi_awprot,
  output logic                                m01_axi_awvalid,
  input  logic                                m01_axi_awready,
  output logic [data_width_p-1:0]             m01_axi_wdata,
  output logic [data_width_p/8-1:0]           m01_axi_wstrb,
  output logic                                m01_axi_wvalid,
  input  logic                                m01_axi_wready,
  input  logic [1:0]                          m01_axi_bresp,
  input  logic                                m01_axi_bvalid,
  output logic                                m01_axi_bready,
  output logic [addr_width_p-1:0]             m01_axi_araddr,
  output logic [2:0]                          m01_axi_arprot,
  output logic                                m01_axi_arvalid,
  input  logic                                m01_axi_arready,
  input  logic [data_width_p-1:0]             m01_axi_rdata,
  input  logic [1:0]                          m01_axi_rresp,
  input  logic                                m01_axi_rvalid,
  output logic                                m01_axi_rready
);

  localparam int idx_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int strb_w = data_width_p / 8;

  typedef logic [idx_w-1:0]        idx_t;
  typedef logic [data_width_p-1:0] data_t;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;
`ifdef AXIL_SEQ_TIMEOUT_EN
  localparam logic [2:0] DRAIN   = 3'd6;
  // Firing two counts early makes RESP visible exactly timeout_cycles_p
  // cycles after the accept cycle (counter reads 0 in the first cycle after accept).
  localparam logic [31:0] to_fire_c = 32'(timeout_cycles_p - 2);
`endif

  logic [2:0]              state_reg;
  idx_t                    ptr_reg;
  idx_t                    gnt_reg;
  logic [addr_width_p-1:0] addr_reg;
  data_t                   data_reg;
  logic [strb_w-1:0]       strb_reg;
  logic                    awvalid_reg;
  logic                    wvalid_reg;
  logic                    arvalid_reg;
  data_t                   resp_data_reg;
  logic                    resp_err_reg;

  idx_t                    gnt_idx;
  logic                    gnt_found;
  logic                    accept;

`ifdef AXIL_SEQ_TIMEOUT_EN
  logic [31:0]             cnt_reg;
  logic                    timeout_reg;
  logic                    drain_reg;
  logic                    b_pend_reg;
  logic                    r_pend_reg;
`else
  logic                    unused_timeout_cfg;
  assign unused_timeout_cfg = (timeout_cycles_p != 0);
`endif

  // Round-robin search: first requester with valid set, starting after the last grant.
  always_comb begin : grant_search
    idx_t cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      cand = idx_t'((int'(ptr_reg) + k) % num_req_p);
      if (!gnt_found && req_v_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign accept = (state_reg == IDLE) && gnt_found;

  // Per-requester ready and response-valid decode; ready is masked during reset.
  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
    assign req_ready_o[gi] = aresetn && accept && (gnt_idx == idx_t'(gi));
    assign resp_v_o[gi]    = (state_reg == RESP) && (gnt_reg == idx_t'(gi));
  end

  assign resp_data_o     = resp_data_reg;
  assign resp_err_o      = resp_err_reg;
  assign m01_axi_awaddr  = addr_reg;
  assign m01_axi_araddr  = addr_reg;
  assign m01_axi_awprot  = 3'b000;
  assign m01_axi_arprot  = 3'b000;
  assign m01_axi_wdata   = data_reg;
  assign m01_axi_wstrb   = strb_reg;
  assign m01_axi_awvalid = awvalid_reg;
  assign m01_axi_wvalid  = wvalid_reg;
  assign m01_axi_arvalid = arvalid_reg;
`ifdef AXIL_SEQ_TIMEOUT_EN
  assign m01_axi_bready  = (state_reg == WR_RESP) || ((state_reg == DRAIN) && b_pend_reg);
  assign m01_axi_rready  = (state_reg == RD_DATA) || ((state_reg == DRAIN) && r_pend_reg);
  assign timeout_o       = timeout_reg;
`else
  assign m01_axi_bready  = (state_reg == WR_RESP);
  assign m01_axi_rready  = (state_reg == RD_DATA);
  assign timeout_o       = 1'b0;
`endif

  // Transaction sequencer: accept, drive AXI request channels, capture response, hand back.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg     <= IDLE;
      ptr_reg       <= idx_t'(num_req_p - 1);
      gnt_reg       <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      strb_reg      <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      resp_data_reg <= '0;
      resp_err_reg  <= 1'b0;
`ifdef AXIL_SEQ_TIMEOUT_EN
      cnt_reg       <= '0;
      timeout_reg   <= 1'b0;
      drain_reg     <= 1'b0;
      b_pend_reg    <= 1'b0;
      r_pend_reg    <= 1'b0;
`endif
    end else begin
      // Request valids drop only on their own handshake, whatever the state.
      if (awvalid_reg && m01_axi_awready) awvalid_reg <= 1'b0;
      if (wvalid_reg && m01_axi_wready)   wvalid_reg  <= 1'b0;
      if (arvalid_reg && m01_axi_arready) arvalid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            gnt_reg  <= gnt_idx;
            ptr_reg  <= gnt_idx;
            addr_reg <= req_addr_i[gnt_idx*addr_width_p +: addr_width_p];
            data_reg <= req_data_i[gnt_idx*data_width_p +: data_width_p];
            strb_reg <= req_strb_i[gnt_idx*strb_w +: strb_w];
            if (req_we_i[gnt_idx]) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= WR_REQ;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if ((!awvalid_reg || m01_axi_awready) && (!wvalid_reg || m01_axi_wready))
            state_reg <= WR_RESP;
        end
        WR_RESP: begin
          if (m01_axi_bvalid) begin
            resp_err_reg  <= (m01_axi_bresp != 2'b00);
            resp_data_reg <= '0;
            state_reg     <= RESP;
          end
        end
        RD_REQ: begin
          if (m01_axi_arready) state_reg <= RD_DATA;
        end
        RD_DATA: begin
          if (m01_axi_rvalid) begin
            resp_err_reg  <= (m01_axi_rresp != 2'b00);
            resp_data_reg <= m01_axi_rdata;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (resp_yumi_i[gnt_reg]) begin
`ifdef AXIL_SEQ_TIMEOUT_EN
            state_reg <= drain_reg ? DRAIN : IDLE;
`else
            state_reg <= IDLE;
`endif
          end
        end
`ifdef AXIL_SEQ_TIMEOUT_EN
        DRAIN: begin
          if (b_pend_reg && m01_axi_bvalid) b_pend_reg <= 1'b0;
          if (r_pend_reg && m01_axi_rvalid) r_pend_reg <= 1'b0;
          if ((!awvalid_reg || m01_axi_awready) && (!wvalid_reg || m01_axi_wready) &&
              (!arvalid_reg || m01_axi_arready) && (!b_pend_reg || m01_axi_bvalid) &&
              (!r_pend_reg || m01_axi_rvalid)) begin
            drain_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase

`ifdef AXIL_SEQ_TIMEOUT_EN
      // Watchdog: overrides the normal flow and remembers which response is still owed.
      if (accept) begin
        cnt_reg <= '0;
      end else if (state_reg inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) begin
        cnt_reg <= cnt_reg + 32'd1;
        if (cnt_reg == to_fire_c) begin
          state_reg     <= RESP;
          resp_err_reg  <= 1'b1;
          resp_data_reg <= data_t'(32'hDEAD_BEEF);
          timeout_reg   <= 1'b1;
          drain_reg     <= 1'b1;
          b_pend_reg    <= (state_reg == WR_REQ) || ((state_reg == WR_RESP) && !m01_axi_bvalid);
          r_pend_reg    <= (state_reg == RD_REQ) || ((state_reg == RD_DATA) && !m01_axi_rvalid);
        end
      end
`endif
    end
  end

endmodule

// File: doc/axil_master_sequencer.md
Name: axil_master_sequencer

Overview:
- Shares the single AXI4-Lite master port to the HP1 interconnect (m01_axi_*) among num_req_p on-fabric requesters.
- Each requester uses a simple valid/ready command and response interface.
- The block round-robin arbitrates between requesters and sequences exactly one AXI-Lite transaction at a time: AW+W then B for writes, AR then R for reads.
- It sits between the host-side shell logic (debug/DMA/config agents) and the m01 port of the top-level FPGA wrapper.

Parameters:
- num_req_p, 2, number of requesters (2..8).
- addr_width_p, 32, AXI address width; equals C_HP1_AXI_ADDR_WIDTH.
- data_width_p, 32, AXI data width; equals C_HP1_AXI_DATA_WIDTH.
- timeout_cycles_p, 4096, response watchdog limit in cycles; used only with the optional feature.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- req_v_i  in  N  per-requester command valid (N = num_req_p).
- req_ready_o  out  N  per-requester command ready; at most one bit set.
- req_we_i  in  N  1 = write, 0 = read.
- req_addr_i  in  N*addr_width_p  packed addresses; requester i at slice i.
- req_data_i  in  N*data_width_p  packed write data.
- req_strb_i  in  N*data_width_p/8  packed write strobes.
- resp_v_o  out  N  response valid; one-hot or zero.
- resp_yumi_i  in  N  response consumed.
- resp_data_o  out  data_width_p  read data; 0 for writes.
- resp_err_o  out  1  1 when the AXI resp is nonzero or the watchdog fired.
- timeout_o  out  1  sticky watchdog flag; constant 0 without the optional feature.
- m01_axi_awaddr/awprot/awvalid  out  addr_width_p/3/1  AW channel; awprot is fixed 3'b000.
- m01_axi_awready  in  1.
- m01_axi_wdata/wstrb/wvalid  out  data_width_p/data_width_p/8/1  W channel.
- m01_axi_wready  in  1.
- m01_axi_bresp/bvalid  in  2/1.  m01_axi_bready  out  1.
- m01_axi_araddr/arprot/arvalid  out  addr_width_p/3/1  AR channel; arprot is fixed 3'b000.
- m01_axi_arready  in  1.
- m01_axi_rdata/rresp/rvalid  in  data_width_p/2/1.  m01_axi_rready  out  1.

Behaviour:
- Reset (aresetn low, asynchronous):
  - State goes to IDLE; round-robin pointer goes to num_req_p-1, so requester 0 has first priority.
  - All outputs are 0, including all AXI valids, bready, rready, resp_v_o and timeout_o.
- A reset mid-transaction abandons the transaction with no further AXI activity; the interconnect is reset alongside.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP, DRAIN (DRAIN exists only with the optional feature).
- IDLE:
  - Grant g is the first index with req_v_i set, searching upward from pointer+1 with wrap-around.
  - req_ready_o[g] = 1 combinationally; all other ready bits are 0. With no requests, all ready bits are 0.
  - On accept: latch addr/data/strb/we/g, set pointer to g, go to WR_REQ if we = 1, else RD_REQ.
- WR_REQ:
  - awvalid and wvalid both assert the cycle after accept.
  - Each deasserts independently after its own handshake.
  - Go to WR_RESP once both handshakes are done, whether in the same cycle or in different cycles.
  - AXI-Lite ordering rules are not violated: W may complete before AW.
- WR_RESP: bready = 1. On bvalid, capture err = (bresp != 0) and data = 0, then go to RESP.
- RD_REQ: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture rdata and err = (rresp != 0), then go to RESP.
- RESP:
  - resp_v_o[g] = 1; resp_data_o and resp_err_o are held stable.
  - On resp_yumi_i[g], go to IDLE.
  - yumi on any other index is ignored.
- Minimum latency with zero-wait AXI: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, resp_v_o at cycle 3, next accept at cycle 4 at the earliest.
- Valid signals never drop before their handshake.
- Address, data and strobe on AXI are the values latched at accept; later changes on req_* have no effect.
- Simultaneous requests are served round-robin, so no requester starves.
  - Example: req0 and req1 both held high are granted 0,1,0,1,...

Optional Feature:
- Macro: AXIL_SEQ_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to WR_REQ/RD_REQ and increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - At count == timeout_cycles_p: go to RESP with resp_err_o = 1 and resp_data_o = 32'hDEAD_BEEF (lower data_width_p bits), and set timeout_o sticky until reset.
  - Pending AXI valids remain asserted per protocol.
  - After RESP, enter DRAIN instead of IDLE. DRAIN completes the outstanding handshakes (aw/w/ar, bready/rready), discards the late response, then goes to IDLE.
- Undefined: no counter, no DRAIN state, timeout_o tied to 0.

Test Plan:
- Single write, req0: addr 0x1000_0010, data 0xA5A5_5A5A, strb 0xF; AXI slave with zero wait and bresp 0 -> one AW/W with those values, resp_v_o = 2'b01 at cycle 3, resp_err_o = 0, resp_data_o = 0.
- Read, req1, addr 0x1000_0020; slave returns rdata 0x1234_5678 with rresp 2'b10 after 5 wait cycles -> resp_v_o = 2'b10, resp_data_o = 0x1234_5678, resp_err_o = 1.
- Both requesters continuously valid for 6 transactions -> grant order 0,1,0,1,0,1; never two ready bits high at once.
- awready delayed 3 cycles with wready immediate, then the reverse -> wvalid drops after 1 cycle and awvalid holds until its handshake; a single B handshake follows; data is unchanged.
- aresetn pulsed low mid-WR_RESP -> all outputs are 0 asynchronously; after release, the first grant goes to requester 0.
- With AXIL_SEQ_TIMEOUT_EN and timeout_cycles_p = 16, slave never asserts bvalid for 20 cycles, then asserts it -> at cycle 16 after accept resp_err_o = 1 with data 0xDEADBEEF and timeout_o = 1; the late B is absorbed in DRAIN; the next request proceeds normally.
